// File: rtl/parser_seg_collect.sv
// Captures the first C_NUM_SEGS beats of each AXIS packet as a header block for the parser, then drains the rest.
// Optional build macro PARSER_SEG_KEEP_MASK_EN: zero captured bytes whose tkeep bit is low.
module parser_seg_collect #(
   parameter int C_AXIS_DATA_WIDTH  = 256,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int C_NUM_SEGS         = 4,
   parameter int C_VLANID_WIDTH     = 12
) (
   input  logic                                    axis_clk,
   input  logic                                    aresetn,
   input  logic [C_AXIS_DATA_WIDTH-1:0]            s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]          s_axis_tkeep,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]           s_axis_tuser,
   input  logic                                    s_axis_tvalid,
   input  logic                                    s_axis_tlast,
   output logic                                    s_axis_tready,
   output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] tdata_segs,
   output logic [C_AXIS_TUSER_WIDTH-1:0]           tuser_1st,
   output logic                                    segs_valid,
   input  logic                                    segs_ready,
   output logic [C_VLANID_WIDTH-1:0]               vlan_id
);

   localparam int C_KEEP_WIDTH = C_AXIS_DATA_WIDTH / 8;
   localparam int C_IDX_WIDTH  = $clog2(C_NUM_SEGS);
   localparam logic [C_IDX_WIDTH-1:0] C_LAST_IDX = C_IDX_WIDTH'(C_NUM_SEGS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      OUTPUT  = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   state_t                        r_state;
   logic [C_IDX_WIDTH-1:0]        r_idx;
   logic                          r_pkt_done;
   logic                          r_segs_valid;
   logic [C_AXIS_TUSER_WIDTH-1:0] r_tuser_1st;
   logic [C_VLANID_WIDTH-1:0]     r_vlan_id;

   logic                          w_accept;
   logic                          w_release;
   logic [C_AXIS_DATA_WIDTH-1:0]  w_beat;

   assign s_axis_tready = aresetn && (r_state != OUTPUT);
   assign w_accept      = s_axis_tvalid && s_axis_tready;
   // segs_ready only means something while a header block is being offered
   assign w_release     = r_segs_valid && segs_ready;

`ifdef PARSER_SEG_KEEP_MASK_EN
   genvar gi;
   for (gi = 0; gi < C_KEEP_WIDTH; gi++) begin : g_keep_mask
      assign w_beat[gi*8 +: 8] = s_axis_tkeep[gi] ? s_axis_tdata[gi*8 +: 8] : 8'h00;
   end
`else
   logic w_unused_keep;
   assign w_unused_keep = ^s_axis_tkeep;
   assign w_beat        = s_axis_tdata;
`endif

   genvar gs;
   for (gs = 0; gs < C_NUM_SEGS; gs++) begin : g_seg
      logic [C_AXIS_DATA_WIDTH-1:0] r_seg;
      logic                         w_we;

      if (gs == 0) begin : g_first
         assign w_we = w_accept && (r_state == IDLE);
      end else begin : g_rest
         assign w_we = w_accept && (r_state == COLLECT) && (r_idx == C_IDX_WIDTH'(gs));
      end

      // Cleared on release so a later short packet reads zero in unused slots
      always_ff @(posedge axis_clk) begin
         if (!aresetn || w_release) begin
            r_seg <= '0;
         end else if (w_we) begin
            r_seg <= w_beat;
         end
      end

      assign tdata_segs[gs*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH] = r_seg;
   end

   always_ff @(posedge axis_clk) begin
      if (!aresetn) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_pkt_done   <= 1'b0;
         r_segs_valid <= 1'b0;
         r_tuser_1st  <= '0;
         r_vlan_id    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_tuser_1st <= s_axis_tuser;
                  r_vlan_id   <= s_axis_tdata[116 +: C_VLANID_WIDTH];
                  r_idx       <= C_IDX_WIDTH'(1);
                  if (s_axis_tlast) begin
                     r_state      <= OUTPUT;
                     r_pkt_done   <= 1'b1;
                     r_segs_valid <= 1'b1;
                  end else begin
                     r_state    <= COLLECT;
                     r_pkt_done <= 1'b0;
                  end
               end
            end
            COLLECT: begin
               if (w_accept) begin
                  if (s_axis_tlast) begin
                     r_state      <= OUTPUT;
                     r_pkt_done   <= 1'b1;
                     r_segs_valid <= 1'b1;
                  end else if (r_idx == C_LAST_IDX) begin
                     r_state      <= OUTPUT;
                     r_pkt_done   <= 1'b0;
                     r_segs_valid <= 1'b1;
                  end else begin
                     r_idx <= r_idx + C_IDX_WIDTH'(1);
                  end
               end
            end
            OUTPUT: begin
               if (w_release) begin
                  r_state      <= r_pkt_done ? IDLE : DRAIN;
                  r_segs_valid <= 1'b0;
                  r_pkt_done   <= 1'b0;
                  r_idx        <= '0;
                  r_tuser_1st  <= '0;
                  r_vlan_id    <= '0;
               end
            end
            DRAIN: begin
               if (w_accept && s_axis_tlast) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tuser_1st  = r_tuser_1st;
   assign segs_valid = r_segs_valid;
   assign vlan_id    = r_vlan_id;

endmodule
